// File: rtl/dmem_pkg.sv
// Shared load/store encodings and helpers for the LSU and the data-memory responder.
// Contents: funct3 constants, responder state enum, access-legality check.
// No ports; imported by dmem_responder and dmem_load_align.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Misalignment, reserved size, unsigned store, or word index beyond the array.
  function automatic logic dmem_access_err(
    input logic        we,
    input logic [2:0]  funct3,
    input logic [31:0] addr,
    input int unsigned depth_words
  );
    logic e;
    e = 1'b0;
    case (funct3[1:0])
      2'b01:   e = addr[0];
      2'b10:   e = |addr[1:0];
      2'b11:   e = 1'b1;
      default: e = 1'b0;
    endcase
    if (we && funct3[2]) e = 1'b1;
    if ({2'b00, addr[31:2]} >= depth_words) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: picks the addressed byte/half out of a memory word and extends it.
// Ports: i_word (raw word), i_off (addr[1:0]), i_funct3 (load kind) -> o_data (extended result).
// Purely combinational; no handshake.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_sh;

  // Move the addressed lane down to bit 0 before extending.
  assign w_sh = i_word >> {i_off, 3'b000};

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_BU:   o_data = {24'h0, w_sh[7:0]};
      F3_H:    o_data = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_HU:   o_data = {16'h0, w_sh[15:0]};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, response after WAIT_CYCLES wait states.
// Ports: clk, rst (sync, active-low); req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err. Response holds until rsp_ready; no new request meanwhile.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_t r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_we;
  logic [2:0]  w_f3;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_be;
  logic [31:0] w_wlane;
  logic [31:0] w_word;
  logic [31:0] w_ld;

  assign w_accept = (r_state == IDLE) && req_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req_valid) w_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (r_cnt == 4'd0) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

  // With zero wait states RESP is entered on the accept edge itself, before the
  // capture registers hold the request, so the live inputs are used then.
  assign w_we    = (r_state == IDLE) ? req_we     : r_we;
  assign w_f3    = (r_state == IDLE) ? req_funct3 : r_f3;
  assign w_addr  = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata  : r_wdata;

  assign w_err = dmem_access_err(w_we, w_f3, w_addr, DEPTH_WORDS);
  assign w_idx = w_addr[AW+1:2];

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = w_wdata;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wlane = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_wdata[15:0]}};
      end
      2'b10: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_word = r_mem[w_idx];

  dmem_load_align u_align (
    .i_word   (w_word),
    .i_off    (w_addr[1:0]),
    .i_funct3 (w_f3),
    .o_data   (w_ld)
  );

  // Contents survive reset; only a legal store on RESP entry writes.
  always_ff @(posedge clk) begin
    if (rst && w_enter_resp && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= 4'(WAIT_CYCLES - 1);
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_rdata <= (w_err || w_we) ? 32'd0 : w_ld;
        r_err   <= w_err;
      end
    end
  end

  // Outputs are forced low while reset is held, whatever state the register holds.
  assign req_ready = rst && (r_state == IDLE);
  assign rsp_valid = rst && (r_state == RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : 32'd0;
  assign rsp_err   = rsp_valid && r_err;

endmodule
